// File: rtl/hpr_heap_alloc_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hpr_heap_alloc_arbiter - round-robin N-client front end to the heap REQ  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module hpr_heap_alloc_arbiter #(
  parameter int N_CLIENTS = 4,
  parameter int MAX_BYTES = 65536,
  parameter int TIMEOUT   = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_CLIENTS-1:0]    cl_req,
  input  logic [64*N_CLIENTS-1:0] cl_size,
  output logic [N_CLIENTS-1:0]    cl_ack,
  output logic                    cl_fail,
  output logic [63:0]             cl_result,
  output logic                    hm_req,
  output logic [63:0]             hm_size,
  input  logic                    hm_ack,
  input  logic                    hm_fail,
  input  logic [63:0]             hm_result,
  output logic [31:0]             alloc_count
);

  localparam int IW = $clog2(N_CLIENTS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [IW-1:0]        grant_q, grant_d;
  logic [63:0]          size_q, size_d;
  logic                 fail_q, fail_d;
  logic [63:0]          res_q, res_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [31:0]          alloc_q, alloc_d;
  logic [N_CLIENTS-1:0] cl_ack_q, cl_ack_d;
  logic                 cl_fail_q, cl_fail_d;
  logic [63:0]          cl_result_q, cl_result_d;
  logic                 hm_req_q, hm_req_d;
  logic [63:0]          hm_size_q, hm_size_d;

  logic                 w_found;
  logic [IW-1:0]        w_pick;
  logic [IW:0]          w_sum;
  logic [63:0]          w_sel_size;
  logic                 w_bad_size;

  // First requesting client at or after the pointer, wrapping around.
  always_comb begin
    w_found = 1'b0;
    w_pick  = ptr_q;
    w_sum   = '0;
    for (int k = 0; k < N_CLIENTS; k++) begin
      w_sum = {1'b0, ptr_q} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(N_CLIENTS)) begin
        w_sum = w_sum - (IW+1)'(N_CLIENTS);
      end
      if (!w_found && cl_req[w_sum[IW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_sum[IW-1:0];
      end
    end
  end

  assign w_sel_size = cl_size[{w_pick, 6'b0} +: 64];
  assign w_bad_size = (w_sel_size == 64'd0) || (w_sel_size > 64'(MAX_BYTES));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    size_d  = size_q;
    fail_d  = fail_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    alloc_d = alloc_q;
    case (state_q)
      S_IDLE: begin
        if (w_found) begin
          grant_d = w_pick;
          size_d  = w_sel_size;
          if (w_bad_size) begin
            fail_d  = 1'b1;
            res_d   = '0;
            state_d = S_RESP;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (hm_ack) begin
          res_d   = hm_result;
          fail_d  = hm_fail;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q + 8'd1 == 8'(TIMEOUT)) begin
            fail_d  = 1'b1;
            res_d   = '0;
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        ptr_d = (grant_q == IW'(N_CLIENTS-1)) ? '0 : grant_q + IW'(1);
        if (!fail_q && alloc_q != 32'hFFFF_FFFF) begin
          alloc_d = alloc_q + 32'd1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each pulse lines up with its state.
  always_comb begin
    cl_ack_d    = '0;
    cl_fail_d   = 1'b0;
    cl_result_d = '0;
    hm_req_d    = 1'b0;
    hm_size_d   = '0;
    if (state_d == S_RESP) begin
      cl_ack_d[grant_d] = 1'b1;
      cl_fail_d         = fail_d;
      cl_result_d       = res_d;
    end
    if (state_d == S_ISSUE) begin
      hm_req_d  = 1'b1;
      hm_size_d = size_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      size_q      <= '0;
      fail_q      <= 1'b0;
      res_q       <= '0;
      cnt_q       <= '0;
      alloc_q     <= '0;
      cl_ack_q    <= '0;
      cl_fail_q   <= 1'b0;
      cl_result_q <= '0;
      hm_req_q    <= 1'b0;
      hm_size_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      size_q      <= size_d;
      fail_q      <= fail_d;
      res_q       <= res_d;
      cnt_q       <= cnt_d;
      alloc_q     <= alloc_d;
      cl_ack_q    <= cl_ack_d;
      cl_fail_q   <= cl_fail_d;
      cl_result_q <= cl_result_d;
      hm_req_q    <= hm_req_d;
      hm_size_q   <= hm_size_d;
    end
  end

  assign cl_ack      = cl_ack_q;
  assign cl_fail     = cl_fail_q;
  assign cl_result   = cl_result_q;
  assign hm_req      = hm_req_q;
  assign hm_size     = hm_size_q;
  assign alloc_count = alloc_q;

endmodule
`default_nettype wire

// File: tb/tb_hpr_heap_alloc_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_hpr_heap_alloc_arbiter - clients and heap manager vs timeline model   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_hpr_heap_alloc_arbiter;

  localparam int          N    = 4;
  localparam int          TO   = 15;
  localparam logic [63:0] MAXB = 64'd65536;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  cl_req;
  logic [255:0]  cl_size;
  logic [N-1:0]  cl_ack;
  logic          cl_fail;
  logic [63:0]   cl_result;
  logic          hm_req;
  logic [63:0]   hm_size;
  logic          hm_ack;
  logic          hm_fail;
  logic [63:0]   hm_result;
  logic [31:0]   alloc_count;

  logic [63:0]   sz [N];
  logic [N-1:0]  stage_req;

  always #5 clk = ~clk;

  assign cl_size = {sz[3], sz[2], sz[1], sz[0]};

  hpr_heap_alloc_arbiter #(
    .N_CLIENTS (N),
    .MAX_BYTES (65536),
    .TIMEOUT   (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cl_req      (cl_req),
    .cl_size     (cl_size),
    .cl_ack      (cl_ack),
    .cl_fail     (cl_fail),
    .cl_result   (cl_result),
    .hm_req      (hm_req),
    .hm_size     (hm_size),
    .hm_ack      (hm_ack),
    .hm_fail     (hm_fail),
    .hm_result   (hm_result),
    .alloc_count (alloc_count)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc = 0, free_cyc = 0;
  int          exp_req = -1, exp_ack = -1, ack_drv = -1, late_drv = -1;
  int          g = 0, ptr = 0, succ = 0, fixed_delay = 1;
  bit          exp_fail, hf_drv, rand_en;
  logic [63:0] g_size, exp_res, heap_next;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic int rr(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return 0;
  endfunction

  function automatic logic [63:0] pick_size();
    int r;
    r = int'($urandom_range(0, 9));
    case (r)
      0:       return 64'd0;
      1:       return MAXB + 64'd1;
      2:       return MAXB;
      3:       return 64'hFFFF_FFFF_FFFF_FFFF;
      default: return 64'($urandom_range(1, 200));
    endcase
  endfunction

  // Decide the whole timeline of a new transaction granted in the current cycle.
  task automatic grant_txn();
    int d, r;
    g        = rr(cl_req, ptr);
    ptr      = (g + 1) % N;
    g_size   = sz[g];
    exp_req  = -1;
    ack_drv  = -1;
    late_drv = -1;
    if (g_size == 64'd0 || g_size > MAXB) begin
      exp_fail = 1'b1;
      exp_res  = '0;
      exp_ack  = cyc + 1;
    end else begin
      exp_req = cyc + 1;
      if (fixed_delay >= 0) begin
        d = fixed_delay;
      end else begin
        r = int'($urandom_range(0, 11));
        d = (r == 0) ? 0 : (r == 1) ? TO : int'($urandom_range(1, 3));
      end
      if (d == 0) begin
        exp_fail = 1'b1;
        exp_res  = '0;
        exp_ack  = cyc + 2 + TO;
        late_drv = exp_ack + 1;
      end else begin
        ack_drv  = cyc + 1 + d;
        exp_ack  = ack_drv + 1;
        hf_drv   = (fixed_delay < 0) && ($urandom_range(0, 7) == 0);
        exp_fail = hf_drv;
        if (hf_drv) begin
          exp_res = '0;
        end else begin
          exp_res   = heap_next;
          heap_next = heap_next + ((g_size + 64'd7) & ~64'd7);
        end
      end
    end
    free_cyc = exp_ack + 1;
  endtask

  task automatic step();
    logic [N-1:0] ack_exp;
    int served;
    @(posedge clk);
    cyc++;
    #1;
    check_eq("hm_req", 64'(hm_req), 64'(cyc == exp_req));
    if (cyc == exp_req) check_eq("hm_size", hm_size, g_size);
    ack_exp = '0;
    if (cyc == exp_ack) ack_exp[g] = 1'b1;
    check_eq("cl_ack", 64'(cl_ack), 64'(ack_exp));
    check_eq("alloc_count", 64'(alloc_count), 64'(succ));
    served = -1;
    if (cyc == exp_ack) begin
      check_eq("cl_fail", 64'(cl_fail), 64'(exp_fail));
      check_eq("cl_result", cl_result, exp_res);
      if (!exp_fail) succ++;
      cl_req[g] = 1'b0;
      served    = g;
    end
    cl_req    = cl_req | stage_req;
    stage_req = '0;
    if (rand_en) begin
      for (int i = 0; i < N; i++) begin
        if (!cl_req[i] && i != served && $urandom_range(0, 3) == 0) begin
          sz[i]     = pick_size();
          cl_req[i] = 1'b1;
        end
      end
    end
    if (cyc >= free_cyc && cl_req != '0) grant_txn();
    hm_ack = (cyc == ack_drv) || (cyc == late_drv);
    if (cyc == ack_drv) begin
      hm_fail   = hf_drv;
      hm_result = hf_drv ? 64'd0 : exp_res;
    end else begin
      hm_fail   = 1'($urandom_range(0, 1));
      hm_result = {$urandom, $urandom};
    end
  endtask

  task automatic raise(input int i, input logic [63:0] s);
    sz[i]        = s;
    stage_req[i] = 1'b1;
  endtask

  task automatic run_idle(input int budget);
    int n;
    n = 0;
    while (!(cl_req == '0 && stage_req == '0 && cyc > exp_ack + 1 && cyc > late_drv)) begin
      if (n >= budget) begin
        check_eq("drain", 64'(cl_req), 64'd0);
        return;
      end
      step();
      n++;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_cl_ack"},    64'(cl_ack),      64'd0);
    check_eq({tag, "_cl_fail"},   64'(cl_fail),     64'd0);
    check_eq({tag, "_cl_result"}, cl_result,        64'd0);
    check_eq({tag, "_hm_req"},    64'(hm_req),      64'd0);
    check_eq({tag, "_hm_size"},   hm_size,          64'd0);
    check_eq({tag, "_alloc"},     64'(alloc_count), 64'd0);
  endtask

  initial begin
    reset     = 1'b0;
    cl_req    = '0;
    stage_req = '0;
    hm_ack    = 1'b0;
    hm_fail   = 1'b0;
    hm_result = '0;
    rand_en   = 1'b0;
    heap_next = 64'd4096;
    for (int i = 0; i < N; i++) sz[i] = '0;
    #3;
    check_outputs_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    raise(0, 64'd24);
    run_idle(50);

    heap_next = 64'd4096;
    raise(1, 64'd5);
    run_idle(50);
    raise(1, 64'd16);
    run_idle(50);

    for (int i = 0; i < N; i++) raise(i, 64'(8 * (i + 1)));
    run_idle(100);
    raise(1, 64'd32);
    run_idle(50);
    for (int i = 0; i < N; i++) raise(i, 64'(16 * (i + 1)));
    run_idle(100);

    raise(0, 64'd0);
    run_idle(50);
    raise(3, MAXB + 64'd1);
    run_idle(50);
    raise(2, MAXB);
    run_idle(50);

    fixed_delay = 0;
    raise(2, 64'd8);
    run_idle(60);
    fixed_delay = TO;
    raise(1, 64'd8);
    run_idle(60);

    // Abort a transaction in WAIT with the pointer away from zero.
    fixed_delay = 1;
    raise(2, 64'd8);
    run_idle(50);
    fixed_delay = 0;
    raise(3, 64'd8);
    repeat (5) step();
    #2 reset = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset     = 1'b1;
    cl_req    = '0;
    stage_req = '0;
    hm_ack    = 1'b0;
    exp_req   = -1;
    exp_ack   = -1;
    ack_drv   = -1;
    late_drv  = -1;
    free_cyc  = 0;
    ptr       = 0;
    succ      = 0;
    fixed_delay = 1;
    for (int i = 0; i < N; i++) raise(i, 64'd40);
    run_idle(100);

    fixed_delay = -1;
    rand_en     = 1'b1;
    repeat (3000) step();
    rand_en = 1'b0;
    run_idle(400);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hpr_heap_alloc_arbiter.md
Name: hpr_heap_alloc_arbiter

Overview:
Round-robin front end that funnels allocation requests from N independent clients onto the single REQ/ACK port of the temporary heap manager (HPR_HEAPMANGER_T0). It guarantees exactly one single-cycle REQ pulse per granted allocation, because the heap manager allocates on every cycle REQ is high. It also screens out illegal sizes and converts a missing ACK into a client-visible failure.

Parameters:
N_CLIENTS, 4, number of requesting clients (2..8)
MAX_BYTES, 65536, largest legal single allocation in bytes
TIMEOUT, 15, WAIT-state cycles before a missing heap ACK is reported as a failure (1..255)

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
cl_req  in  N_CLIENTS  per-client level request
cl_size  in  64*N_CLIENTS  per-client SIZE_IN_BYTES; client i uses bits [64*i+63:64*i]
cl_ack  out  N_CLIENTS  one-cycle completion pulse, one-hot
cl_fail  out  1  qualifies cl_ack: 1 = allocation failed
cl_result  out  64  allocated byte address; valid only while cl_ack is high
hm_req  out  1  to heap manager REQ
hm_size  out  64  to heap manager SIZE_IN_BYTES
hm_ack  in  1  from heap manager ACK
hm_fail  in  1  from heap manager FAIL
hm_result  in  64  from heap manager RESULT
alloc_count  out  32  successful allocations since reset, saturating at 0xFFFFFFFF

Behaviour:
- Reset (reset=0, asynchronous): state IDLE. cl_ack=0, cl_fail=0, cl_result=0, hm_req=0, hm_size=0, alloc_count=0. Round-robin pointer = 0. Wait counter = 0.
- All outputs are registered. There are no combinational paths from input to output.
- State IDLE:
  - If any cl_req bit is set, grant the first set bit at or after the pointer, searching upward and wrapping modulo N_CLIENTS. Latch the grant index and that client's size.
  - If the size is 0 or greater than MAX_BYTES, go to RESP with fail=1. No heap request is issued.
  - Otherwise go to ISSUE.
- State ISSUE: hm_req=1 and hm_size=latched size for exactly this one cycle. Next state is WAIT with the counter cleared. hm_req is 0 in every other state.
- State WAIT:
  - When hm_ack=1, capture hm_result and hm_fail, then go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT, go to RESP with fail=1 and result 0.
- State RESP:
  - cl_ack[grant]=1 for exactly this cycle. cl_fail and cl_result carry the captured values.
  - On exit, the pointer becomes (grant+1) mod N_CLIENTS.
  - alloc_count increments if fail=0, saturating at the maximum.
  - Next state is IDLE.
- Client rule: a client holds cl_req and cl_size stable until it samples cl_ack=1. It deasserts cl_req at that same edge. The IDLE cycle following RESP therefore never re-grants the served request.
- Latency, no contention, heap ACK one cycle after REQ: cl_req seen in IDLE at cycle 0, hm_req in cycle 1, hm_ack in cycle 2, cl_ack in cycle 3. Peak throughput is one allocation per 4 cycles. A locally rejected size gives cl_ack in cycle 1.
- hm_ack arriving outside WAIT (for example, a late ACK after a timeout) is ignored and never produces a cl_ack.
- cl_req dropped by a non-granted client has no effect. Dropping cl_req after grant is a protocol violation; the transaction still completes.
- Simultaneous requests: exactly one grant per transaction. Under continuous contention every requesting client is served within N_CLIENTS transactions.
- Reset mid-transaction aborts immediately with no cl_ack. The heap manager has its own reset; base-address consistency across resets is the system's responsibility.

Test Plan:
- Single request: client 0 requests size 24, heap base 4096 -> hm_req pulses exactly one cycle with hm_size=24; cl_ack[0] three cycles after the request with cl_result=4096, cl_fail=0; alloc_count=1.
- Back-to-back from client 1, sizes 5 then 16 -> results 4096 then 4104; exactly two hm_req pulses total.
- All four clients request together with the pointer at 0 -> grant order 0,1,2,3; with the pointer at 2 -> order 2,3,0,1; no client served twice.
- Size 0 and size MAX_BYTES+1 -> cl_ack with cl_fail=1 one cycle after the request; hm_req never asserted; alloc_count unchanged.
- Heap model withholds ACK -> cl_fail=1 and cl_result=0 after 15 WAIT cycles; a late hm_ack then produces no cl_ack.
- reset pulled low while in WAIT -> all outputs 0 asynchronously; after release, a fresh request completes normally with the pointer at 0.
